// File: rtl/dl_pipe_reg_rv.sv
// Elastic pipeline register with valid/ready on both sides and a two-entry skid.
// Every output is a flop: out_vld, out_data, in_rdy and occ.
module dl_pipe_reg_rv #(
    parameter int unsigned          WIDTH    = 32,
    parameter logic [WIDTH-1:0]     RST_DATA = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occ
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Handshake: a transfer happens on a side when its valid and ready are both 1
    // at a rising edge. Producer may not withdraw data while in_vld && !in_rdy is
    // expected to be held; consumer sees out_data stable while out_vld && !out_rdy.
    state_t           state;
    logic [WIDTH-1:0] skid;
    logic             in_fire;
    logic             out_fire;

    assign in_fire  = in_vld && in_rdy;
    assign out_fire = out_vld && out_rdy;

    // occ mirrors the state encoding, so it doubles as the visible FSM state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            out_vld  <= 1'b0;
            in_rdy   <= 1'b0;
            occ      <= 2'd0;
            out_data <= RST_DATA;
            skid     <= RST_DATA;
        end else if (flush) begin
            // Squash: anything accepted this cycle is dropped; a pop this cycle
            // was already taken by the consumer.
            state   <= EMPTY;
            out_vld <= 1'b0;
            in_rdy  <= 1'b1;
            occ     <= 2'd0;
        end else begin
            case (state)
                EMPTY: begin
                    in_rdy <= 1'b1;
                    if (in_fire) begin
                        out_data <= in_data;
                        state    <= ONE;
                        out_vld  <= 1'b1;
                        occ      <= 2'd1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        out_data <= in_data;
                    end else if (in_fire) begin
                        skid   <= in_data;
                        state  <= FULL;
                        occ    <= 2'd2;
                        in_rdy <= 1'b0;
                    end else if (out_fire) begin
                        state   <= EMPTY;
                        out_vld <= 1'b0;
                        occ     <= 2'd0;
                    end
                end
                FULL: begin
                    // in_rdy is low here, so only the consumer side can move.
                    if (out_fire) begin
                        out_data <= skid;
                        state    <= ONE;
                        occ      <= 2'd1;
                        in_rdy   <= 1'b1;
                    end
                end
                default: begin
                    state   <= EMPTY;
                    out_vld <= 1'b0;
                    occ     <= 2'd0;
                    in_rdy  <= 1'b1;
                end
            endcase
        end
    end

endmodule
